// File: rtl/data_ram_master_pkg.sv
// Shared definitions for the data RAM master: op encodings, RAM control levels
// and FSM state encoding.
package data_ram_master_pkg;

    typedef enum logic [2:0] {
        OpLb  = 3'd0,
        OpLbu = 3'd1,
        OpLh  = 3'd2,
        OpLhu = 3'd3,
        OpLw  = 3'd4,
        OpSb  = 3'd5,
        OpSh  = 3'd6,
        OpSw  = 3'd7
    } op_e;

    localparam logic        CHIP_ENABLE   = 1'b1;
    localparam logic        CHIP_DISABLE  = 1'b0;
    localparam logic        WRITE_ENABLE  = 1'b1;
    localparam logic        WRITE_DISABLE = 1'b0;
    localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StResp   = 2'd2
    } state_e;

    function automatic logic op_is_store(logic [2:0] op);
        return op[2] & (op[1] | op[0]);
    endfunction

endpackage

// File: rtl/data_ram_master_if.sv
// Pipeline request/response handshake plus the data RAM port.
// master: the data_ram_master itself; slave: pipeline and RAM around it.
interface data_ram_master_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TAG_W  = 5
);
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [TAG_W-1:0]  req_tag;

    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic [TAG_W-1:0]  resp_tag;
    logic              resp_misalign;
    logic [ADDR_W-1:0] resp_addr;

    logic              ram_en;
    logic              ram_write_en;
    logic [3:0]        ram_write_sel;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_write_data;
    logic [DATA_W-1:0] ram_read_data;

    modport master (
        input  req_valid, req_op, req_addr, req_wdata, req_tag, resp_ready, ram_read_data,
        output req_ready, resp_valid, resp_rdata, resp_tag, resp_misalign, resp_addr,
               ram_en, ram_write_en, ram_write_sel, ram_addr, ram_write_data
    );

    modport slave (
        output req_valid, req_op, req_addr, req_wdata, req_tag, resp_ready, ram_read_data,
        input  req_ready, resp_valid, resp_rdata, resp_tag, resp_misalign, resp_addr,
               ram_en, ram_write_en, ram_write_sel, ram_addr, ram_write_data
    );
endinterface

// File: rtl/data_ram_master_lsu_lane_align.sv
// Big-endian byte-lane mapping: store lane selects/replication, load extraction
// with sign/zero extension, and alignment fault detection.
module data_ram_master_lsu_lane_align
    import data_ram_master_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  write_sel,
    output logic [31:0] write_data,
    output logic [31:0] load_data,
    output logic        misalign,
    output logic        store
);
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    // Lane 0 (lowest address) lives in the most significant byte.
    always_comb begin
        rd_byte = rdata[31:24];
        unique case (offset)
            2'd0: rd_byte = rdata[31:24];
            2'd1: rd_byte = rdata[23:16];
            2'd2: rd_byte = rdata[15:8];
            2'd3: rd_byte = rdata[7:0];
            default: rd_byte = rdata[31:24];
        endcase
        rd_half = offset[1] ? rdata[15:0] : rdata[31:16];
    end

    always_comb begin
        write_sel  = 4'b0000;
        write_data = ZERO_WORD;
        load_data  = ZERO_WORD;
        misalign   = 1'b0;
        store      = op_is_store(op);
        unique case (op_e'(op))
            OpLb:  load_data = {{24{rd_byte[7]}}, rd_byte};
            OpLbu: load_data = {24'h000000, rd_byte};
            OpLh: begin
                load_data = {{16{rd_half[15]}}, rd_half};
                misalign  = offset[0];
            end
            OpLhu: begin
                load_data = {16'h0000, rd_half};
                misalign  = offset[0];
            end
            OpLw: begin
                load_data = rdata;
                misalign  = |offset;
            end
            OpSb: begin
                write_sel  = 4'b1000 >> offset;
                write_data = {4{wdata[7:0]}};
            end
            OpSh: begin
                write_sel  = offset[1] ? 4'b0011 : 4'b1100;
                write_data = {2{wdata[15:0]}};
                misalign   = offset[0];
            end
            OpSw: begin
                write_sel  = 4'b1111;
                write_data = wdata;
                misalign   = |offset;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/data_ram_master.sv
// MEM-stage data RAM initiator: one load/store at a time, IDLE -> ACCESS -> RESP,
// misaligned ops skip ACCESS and fault straight to RESP.
module data_ram_master
    import data_ram_master_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TAG_W  = 5
) (
    input logic               clk,
    input logic               rst,
    data_ram_master_if.master bus
);
    state_e            state_q;
    logic [2:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [TAG_W-1:0]  tag_q;

    logic              req_ready_q;
    logic              resp_valid_q;
    logic              resp_misalign_q;
    logic [DATA_W-1:0] resp_rdata_q;
    logic [TAG_W-1:0]  resp_tag_q;
    logic [ADDR_W-1:0] resp_addr_q;

    logic              ram_en_q;
    logic              ram_we_q;
    logic [3:0]        ram_sel_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [DATA_W-1:0] ram_wdata_q;

    logic [2:0]        lane_op;
    logic [1:0]        lane_offset;
    logic [3:0]        lane_sel;
    logic [DATA_W-1:0] lane_wdata;
    logic [DATA_W-1:0] lane_load;
    logic              lane_misalign;
    logic              lane_store;
    logic              accept;

    // In IDLE the aligner decodes the incoming request; in ACCESS the latched one.
    assign lane_op     = (state_q == StIdle) ? bus.req_op : op_q;
    assign lane_offset = (state_q == StIdle) ? bus.req_addr[1:0] : addr_q[1:0];
    assign accept      = bus.req_valid & req_ready_q;

    data_ram_master_lsu_lane_align u_lane_align (
        .op         (lane_op),
        .offset     (lane_offset),
        .wdata      (bus.req_wdata),
        .rdata      (bus.ram_read_data),
        .write_sel  (lane_sel),
        .write_data (lane_wdata),
        .load_data  (lane_load),
        .misalign   (lane_misalign),
        .store      (lane_store)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q         <= StIdle;
            op_q            <= '0;
            addr_q          <= '0;
            tag_q           <= '0;
            req_ready_q     <= 1'b0;
            resp_valid_q    <= 1'b0;
            resp_misalign_q <= 1'b0;
            resp_rdata_q    <= '0;
            resp_tag_q      <= '0;
            resp_addr_q     <= '0;
            ram_en_q        <= CHIP_DISABLE;
            ram_we_q        <= WRITE_DISABLE;
            ram_sel_q       <= '0;
            ram_addr_q      <= '0;
            ram_wdata_q     <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    req_ready_q <= 1'b1;
                    if (accept) begin
                        op_q        <= bus.req_op;
                        addr_q      <= bus.req_addr;
                        tag_q       <= bus.req_tag;
                        req_ready_q <= 1'b0;
                        if (lane_misalign) begin
                            state_q         <= StResp;
                            resp_valid_q    <= 1'b1;
                            resp_misalign_q <= 1'b1;
                            resp_rdata_q    <= '0;
                            resp_tag_q      <= bus.req_tag;
                            resp_addr_q     <= bus.req_addr;
                        end else begin
                            state_q     <= StAccess;
                            ram_en_q    <= CHIP_ENABLE;
                            ram_we_q    <= lane_store ? WRITE_ENABLE : WRITE_DISABLE;
                            ram_sel_q   <= lane_sel;
                            ram_addr_q  <= {bus.req_addr[ADDR_W-1:2], 2'b00};
                            ram_wdata_q <= lane_wdata;
                        end
                    end
                end
                StAccess: begin
                    state_q         <= StResp;
                    ram_en_q        <= CHIP_DISABLE;
                    ram_we_q        <= WRITE_DISABLE;
                    ram_sel_q       <= '0;
                    ram_addr_q      <= '0;
                    ram_wdata_q     <= '0;
                    resp_valid_q    <= 1'b1;
                    resp_misalign_q <= 1'b0;
                    resp_rdata_q    <= lane_load;
                    resp_tag_q      <= tag_q;
                    resp_addr_q     <= addr_q;
                end
                StResp: begin
                    if (bus.resp_ready) begin
                        state_q         <= StIdle;
                        req_ready_q     <= 1'b1;
                        resp_valid_q    <= 1'b0;
                        resp_misalign_q <= 1'b0;
                        resp_rdata_q    <= '0;
                        resp_tag_q      <= '0;
                        resp_addr_q     <= '0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.req_ready      = req_ready_q;
    assign bus.resp_valid     = resp_valid_q;
    assign bus.resp_misalign  = resp_misalign_q;
    assign bus.resp_rdata     = resp_rdata_q;
    assign bus.resp_tag       = resp_tag_q;
    assign bus.resp_addr      = resp_addr_q;
    assign bus.ram_en         = ram_en_q;
    assign bus.ram_write_en   = ram_we_q;
    assign bus.ram_write_sel  = ram_sel_q;
    assign bus.ram_addr       = ram_addr_q;
    assign bus.ram_write_data = ram_wdata_q;
endmodule
